stopwatch_ctrl: RTL

Control sequencer for the stopwatch digit counter. It synchronizes and debounces the user pause and clear buttons and synchronizes the adjust and select switches. It divides the single system clock into normal-rate and fast-rate ticks, and runs a mode FSM. Its outputs are single-cycle increment and clear strobes for the digit counter, plus a blink flag for the display driver. All timing is derived from one clock; the counter and display need no derived clocks.

---
 rtl/stopwatch_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control sequencer for the stopwatch digit counter.
// Synchronizes and debounces the pause/clear buttons, synchronizes the
// adjust/select switches, derives normal and fast ticks from i_clk, and
// runs the RUN/PAUSE/ADJ/CLR mode FSM.
//
// Ports
//   i_clk        system clock, all logic on posedge
//   i_rst        asynchronous active-high reset
//   i_btn_pause  raw pause button (async, active-high)
//   i_btn_clr    raw clear button (async, active-high)
//   i_sw_adj     raw adjust switch, 1 = adjust mode
//   i_sw_sel     raw select switch, 1 = seconds, 0 = minutes
//   o_inc_norm   one-cycle strobe: advance full count by one second
//   o_inc_sec    one-cycle strobe: advance seconds field only
//   o_inc_min    one-cycle strobe: advance minutes field only
//   o_clr        one-cycle strobe: zero all digits
//   o_blink      display enable for the selected field
//   o_paused     pause flag level
//   o_mode       00 RUN, 01 PAUSE, 10 ADJ, 11 CLR
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | counting, inc_norm on every normal tick
// PAUSE | counting halted, prescaler keeps free-running
// ADJ   | manual adjust, inc_sec/inc_min on fast ticks, blink toggles
// CLR   | single-cycle clear strobe, then RUN or ADJ

// Two-flop synchronizer plus debounce filter; emits a one-cycle pulse on
// the rising edge of the debounced level.
module stopwatch_ctrl_db #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                // this edge is the DB_CYCLES-th consecutive differing cycle
                r_cnt   <= '0;
                r_level <= r_s2;
                r_press <= r_s2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;
endmodule

module stopwatch_ctrl #(
    parameter int NORM_DIV  = 100_000_000,
    parameter int FAST_DIV  = 50_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_pause,
    input  logic       i_btn_clr,
    input  logic       i_sw_adj,
    input  logic       i_sw_sel,
    output logic       o_inc_norm,
    output logic       o_inc_sec,
    output logic       o_inc_min,
    output logic       o_clr,
    output logic       o_blink,
    output logic       o_paused,
    output logic [1:0] o_mode
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_PAUSE = 2'b01,
        ST_ADJ   = 2'b10,
        ST_CLR   = 2'b11
    } state_t;

    localparam int NW = $clog2(NORM_DIV);
    localparam int FW = $clog2(FAST_DIV);
    localparam logic [NW-1:0] NORM_LAST = NW'(NORM_DIV - 1);
    localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV - 1);

    logic          w_pause_p;
    logic          w_clr_p;
    logic          r_adj_s1, r_adj_s2;
    logic          r_sel_s1, r_sel_s2;
    logic [NW-1:0] r_norm_cnt;
    logic [FW-1:0] r_fast_cnt;
    logic          w_norm_tk;
    logic          w_fast_tk;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_paused;
    logic          w_paused_nxt;
    logic          w_adj_entry;
    logic          w_inc_norm_nxt;
    logic          w_inc_sec_nxt;
    logic          w_inc_min_nxt;
    logic          w_clr_nxt;
    logic          w_blink_nxt;
    logic          r_inc_norm;
    logic          r_inc_sec;
    logic          r_inc_min;
    logic          r_clr;
    logic          r_blink;

    stopwatch_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_btn_pause),
        .o_press (w_pause_p)
    );

    stopwatch_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_btn_clr),
        .o_press (w_clr_p)
    );

    // Switches are levels; synchronize only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_adj_s1 <= 1'b0;
            r_adj_s2 <= 1'b0;
            r_sel_s1 <= 1'b0;
            r_sel_s2 <= 1'b0;
        end else begin
            r_adj_s1 <= i_sw_adj;
            r_adj_s2 <= r_adj_s1;
            r_sel_s1 <= i_sw_sel;
            r_sel_s2 <= r_sel_s1;
        end
    end

    assign w_norm_tk   = (r_norm_cnt == NORM_LAST);
    assign w_fast_tk   = (r_fast_cnt == FAST_LAST);
    assign w_adj_entry = (w_state_nxt == ST_ADJ) && (r_state != ST_ADJ);

    // norm_cnt free-runs through PAUSE and ADJ; only a clear re-phases it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_norm_cnt <= '0;
            r_fast_cnt <= '0;
        end else begin
            if (w_clr_p || w_norm_tk) begin
                r_norm_cnt <= '0;
            end else begin
                r_norm_cnt <= r_norm_cnt + NW'(1);
            end
            // restart the fast phase on ADJ entry so the first adjust tick
            // lands a full FAST_DIV after entry
            if (w_clr_p || w_adj_entry || w_fast_tk) begin
                r_fast_cnt <= '0;
            end else begin
                r_fast_cnt <= r_fast_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_RUN;
            r_paused <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_paused <= w_paused_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_paused_nxt = r_paused;
        if (w_clr_p) begin
            w_state_nxt  = ST_CLR;
            w_paused_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_CLR: begin
                    w_state_nxt = r_adj_s2 ? ST_ADJ : ST_RUN;
                end
                ST_RUN: begin
                    if (r_adj_s2) begin
                        w_state_nxt = ST_ADJ;
                    end else if (w_pause_p) begin
                        w_state_nxt  = ST_PAUSE;
                        w_paused_nxt = ~r_paused;
                    end
                end
                ST_PAUSE: begin
                    if (r_adj_s2) begin
                        w_state_nxt = ST_ADJ;
                    end else if (w_pause_p) begin
                        w_state_nxt  = ST_RUN;
                        w_paused_nxt = ~r_paused;
                    end
                end
                ST_ADJ: begin
                    if (!r_adj_s2) begin
                        w_state_nxt = r_paused ? ST_PAUSE : ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Strobes are qualified with the next state so that each registered
    // strobe agrees with the mode register loaded on the same edge; this is
    // also what drops inc_norm when a clear lands on a normal tick.
    always_comb begin
        w_inc_norm_nxt = w_norm_tk && (w_state_nxt == ST_RUN);
        w_inc_sec_nxt  = w_fast_tk && (r_state == ST_ADJ) && (w_state_nxt == ST_ADJ) && r_sel_s2;
        w_inc_min_nxt  = w_fast_tk && (r_state == ST_ADJ) && (w_state_nxt == ST_ADJ) && !r_sel_s2;
        w_clr_nxt      = (w_state_nxt == ST_CLR);
        w_blink_nxt    = 1'b1;
        if ((w_state_nxt == ST_ADJ) && (r_state == ST_ADJ)) begin
            w_blink_nxt = w_fast_tk ? ~r_blink : r_blink;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inc_norm <= 1'b0;
            r_inc_sec  <= 1'b0;
            r_inc_min  <= 1'b0;
            r_clr      <= 1'b0;
            r_blink    <= 1'b1;
        end else begin
            r_inc_norm <= w_inc_norm_nxt;
            r_inc_sec  <= w_inc_sec_nxt;
            r_inc_min  <= w_inc_min_nxt;
            r_clr      <= w_clr_nxt;
            r_blink    <= w_blink_nxt;
        end
    end

    assign o_inc_norm = r_inc_norm;
    assign o_inc_sec  = r_inc_sec;
    assign o_inc_min  = r_inc_min;
    assign o_clr      = r_clr;
    assign o_blink    = r_blink;
    assign o_paused   = r_paused;
    assign o_mode     = r_state;
endmodule
